lcd_pixel_packer: RTL and testbench

//  Buffers the VPU pixel stream and packs each 32-bit colour into LCD bus bytes for the ILI9341 8-bit parallel driver.

---
 rtl/lcd_pkg.sv | 58 +++++
 rtl/sync_fifo.sv | 51 +++++
 rtl/lcd_pixel_packer.sv | 122 ++++++++++++
 tb/tb_lcd_pixel_packer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and pixel packing helpers for lcd_pixel_packer.
// Define LCD_PIXEL_PACKER_RGB666_EN to select 18-bit (3 bytes/pixel) output; the default is RGB565.
package lcd_pkg;

    localparam int CNT_W = 17;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } rgb666_t;

`ifdef LCD_PIXEL_PACKER_RGB666_EN
    localparam int BYTES_PER_PIXEL = 3;
    typedef rgb666_t pix_t;
    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, BYTE2} pack_fsm_e;
`else
    localparam int BYTES_PER_PIXEL = 2;
    typedef rgb565_t pix_t;
    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} pack_fsm_e;
`endif

    typedef struct packed {
        logic sof;
        pix_t pix;
    } entry_t;

    // Colour input is {A,B,G,R}; alpha is dropped and each channel keeps its MSBs.
    function automatic pix_t pack_color(input logic [31:0] c);
`ifdef LCD_PIXEL_PACKER_RGB666_EN
        return '{r: c[7:2], g: c[15:10], b: c[23:18]};
`else
        return '{r: c[7:3], g: c[15:10], b: c[23:19]};
`endif
    endfunction

    function automatic logic [7:0] pixel_byte(input pix_t p, input logic [1:0] idx);
`ifdef LCD_PIXEL_PACKER_RGB666_EN
        case (idx)
            2'd0:    return {p.r, 2'b00};
            2'd1:    return {p.g, 2'b00};
            default: return {p.b, 2'b00};
        endcase
`else
        case (idx)
            2'd0:    return {p.r, p.g[5:3]};
            default: return {p.g[2:0], p.b};
        endcase
`endif
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes into a full FIFO are ignored even if a pop coincides.
// Power-of-two DEPTH so the pointers wrap naturally.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: storage is not reset; pointers and level alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (!do_push && do_pop) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/lcd_pixel_packer.sv
// Buffers VPU pixels and serialises them into ILI9341 8-bit bus bytes with frame tags.
// LCD_PIXEL_PACKER_RGB666_EN selects 3 bytes/pixel (18-bit); default is RGB565, 2 bytes/pixel.
module lcd_pixel_packer
    import lcd_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    input  logic [31:0]            pix_color,
    output logic                   pix_ready,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_sof,
    output logic                   byte_eof,
    input  logic                   byte_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(FRAME_PIXELS - 1);
`ifdef LCD_PIXEL_PACKER_RGB666_EN
    localparam pack_fsm_e LAST_BYTE = BYTE2;
`else
    localparam pack_fsm_e LAST_BYTE = BYTE1;
`endif

    entry_t           wr_entry;
    entry_t           rd_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             xfer;
    logic             last_xfer;
    pack_fsm_e        state;
    pix_t             cur_pix;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_base;

    assign wr_entry  = '{sof: pix_sof, pix: pack_color(pix_color)};
    assign pix_ready = !fifo_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pix_valid),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // count_base is the pixel count after any final-byte transfer this cycle; a popped sof
    // entry is judged against it, so a frame that wrapped cleanly restarts without error.
    always_comb begin
        xfer       = byte_valid && byte_ready;
        last_xfer  = xfer && (state == LAST_BYTE);
        pop        = !fifo_empty && ((state == IDLE) || last_xfer);
        count_base = count;
        if (last_xfer) count_base = (count == LAST_PIXEL) ? '0 : count + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cur_pix    <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_sof   <= 1'b0;
            byte_eof   <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (pix_valid && fifo_full) overflow <= 1'b1;
            count <= count_base;
            if (pop) begin
                state      <= BYTE0;
                cur_pix    <= rd_entry.pix;
                byte_valid <= 1'b1;
                byte_data  <= pixel_byte(rd_entry.pix, 2'd0);
                byte_sof   <= rd_entry.sof;
                byte_eof   <= 1'b0;
                if (rd_entry.sof) begin
                    count <= '0;
                    if (count_base != '0) frame_err <= 1'b1;
                end
            end else if (xfer) begin
                byte_sof <= 1'b0;
                case (state)
                    BYTE0: begin
                        state     <= BYTE1;
                        byte_data <= pixel_byte(cur_pix, 2'd1);
                        byte_eof  <= (LAST_BYTE == BYTE1) && (count == LAST_PIXEL);
                    end
`ifdef LCD_PIXEL_PACKER_RGB666_EN
                    BYTE1: begin
                        state     <= BYTE2;
                        byte_data <= pixel_byte(cur_pix, 2'd2);
                        byte_eof  <= (count == LAST_PIXEL);
                    end
`endif
                    default: begin
                        state      <= IDLE;
                        byte_valid <= 1'b0;
                        byte_eof   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_pixel_packer.sv
// Directed self-checking bench for lcd_pixel_packer (honours LCD_PIXEL_PACKER_RGB666_EN).
// A small frame size keeps the full-frame step short.
module tb_lcd_pixel_packer;

    localparam int DEPTH = 16;
    localparam int FP    = 150;
`ifdef LCD_PIXEL_PACKER_RGB666_EN
    localparam int BPP = 3;
`else
    localparam int BPP = 2;
`endif

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_valid;
    logic        pix_sof;
    logic [31:0] pix_color;
    logic        pix_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_sof;
    logic        byte_eof;
    logic        byte_ready;
    logic [4:0]  level;
    logic        overflow;
    logic        frame_err;

    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   pix_id  = 0;
    int   m_count = 0;
    logic m_err   = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    lcd_pixel_packer #(.DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_color  (pix_color),
        .pix_ready  (pix_ready),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_sof   (byte_sof),
        .byte_eof   (byte_eof),
        .byte_ready (byte_ready),
        .level      (level),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_color(input int i);
        return {8'(i * 7 + 1), 8'(i * 53 + 17), 8'(i * 29 + 5), 8'(i * 11 + 130)};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] c, input int k);
        logic [7:0] r, g, b;
        r = c[7:0];
        g = c[15:8];
        b = c[23:16];
`ifdef LCD_PIXEL_PACKER_RGB666_EN
        if (k == 0) return {r[7:2], 2'b00};
        if (k == 1) return {g[7:2], 2'b00};
        return {b[7:2], 2'b00};
`else
        if (k == 0) return {r[7:3], g[7:5]};
        return {g[4:2], b[7:3]};
`endif
    endfunction

    // Frame model: sof restarts the count (error if mid-frame), eof on the final byte of pixel FP-1.
    task automatic model_push(input logic [31:0] c, input logic sof);
        exp_t e;
        if (sof) begin
            if (m_count != 0) m_err = 1'b1;
            m_count = 0;
        end
        for (int k = 0; k < BPP; k++) begin
            e.data = exp_byte(c, k);
            e.sof  = sof && (k == 0);
            e.eof  = (k == BPP - 1) && (m_count == FP - 1);
            e.err  = m_err;
            e.last = (k == BPP - 1);
            q.push_back(e);
        end
        m_count = (m_count == FP - 1) ? 0 : m_count + 1;
    endtask

    task automatic stream(input string tag, input int n, input int sof_a, input int sof_b,
                          input int gap, input bit strict, input bit lvl1);
        int   pushed  = 0;
        bit   started = 1'b0;
        bit   mid     = 1'b0;
        bit   done    = 1'b0;
        int   budget;
        exp_t e;
        budget     = (n * BPP + q.size()) * gap * 2 + 64;
        byte_ready = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pushed == n && q.size() == 0) begin
                done = 1'b1;
                break;
            end
            if (byte_valid) begin
                if (q.size() == 0) begin
                    check({tag, "_spurious"}, byte_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    check({tag, "_byte"}, {frame_err, byte_sof, byte_eof, byte_data},
                          {e.err, e.sof, e.eof, e.data});
                    mid     = !e.last;
                    started = 1'b1;
                end
            end else begin
                if (mid) check({tag, "_gap_in_pixel"}, byte_valid, 1'b1);
                else if (strict && started && q.size() > 0) check({tag, "_bubble"}, byte_valid, 1'b1);
                mid = 1'b0;
            end
            if (lvl1) check({tag, "_level_le1"}, level <= 5'd1, 1'b1);
            if (pushed < n && cyc % gap == 0 && pix_ready) begin
                pix_valid = 1'b1;
                pix_sof   = (pushed == sof_a) || (pushed == sof_b);
                pix_color = gen_color(pix_id);
                model_push(pix_color, pix_sof);
                pix_id++;
                pushed++;
            end else begin
                pix_valid = 1'b0;
                pix_sof   = 1'b0;
            end
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        if (!done) check({tag, "_timeout"}, q.size() + n - pushed, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  t1_b [3];
        logic [31:0] c6;
`ifdef LCD_PIXEL_PACKER_RGB666_EN
        t1_b[0] = 8'h40; t1_b[1] = 8'h80; t1_b[2] = 8'hFC;
`else
        t1_b[0] = 8'h44; t1_b[1] = 8'h1F; t1_b[2] = 8'h00;
`endif
        // Reset values.
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_color = '0; byte_ready = 1'b1;
        tick(); tick();
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_pix_ready", pix_ready, 1'b1);
        check("rst_level", level, 0);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_flags", {byte_sof, byte_eof, overflow, frame_err}, 4'b0000);
        reset = 1'b0;
        tick();

        // One pixel: push at edge N, first byte visible after N+1.
        check("t1_ready", pix_ready, 1'b1);
        pix_valid = 1'b1; pix_sof = 1'b1; pix_color = 32'h00FF8040;
        tick();
        pix_valid = 1'b0; pix_sof = 1'b0;
        check("t1_level_after_push", level, 1);
        check("t1_valid_latency", byte_valid, 1'b0);
        for (int k = 0; k < BPP; k++) begin
            tick();
            check("t1_byte", {byte_valid, byte_sof, byte_eof, byte_data}, {1'b1, k == 0, 1'b0, t1_b[k]});
        end
        tick();
        check("t1_idle", byte_valid, 1'b0);
        check("t1_level_idle", level, 0);
        m_count = 1;

        // Fill with the driver stalled: one pixel sits in the serializer, 16 in the FIFO.
        byte_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            pix_valid = 1'b1; pix_sof = 1'b0; pix_color = gen_color(pix_id);
            model_push(pix_color, 1'b0);
            pix_id++;
            tick();
        end
        check("t2_level_full", level, DEPTH);
        check("t2_ready_low", pix_ready, 1'b0);
        check("t2_no_overflow_yet", overflow, 1'b0);
        pix_color = gen_color(999);
        tick();
        pix_valid = 1'b0;
        check("t2_overflow", overflow, 1'b1);
        check("t2_level_after_drop", level, DEPTH);
        tick(); tick(); tick();
        check("t2_overflow_sticky", overflow, 1'b1);
        check("t2_hold", {byte_valid, byte_data}, {1'b1, q[0].data});
        stream("t2_drain", 0, -1, -1, 1, 1'b1, 1'b0);
        check("t2_drained_valid", byte_valid, 1'b0);
        check("t2_drained_level", level, 0);

        // Slow pixel source: each pixel's bytes are contiguous, FIFO never exceeds one entry.
        stream("t3", 8, -1, -1, 4, 1'b0, 1'b1);

        // Asynchronous reset mid-pixel, between edges.
        byte_ready = 1'b0;
        c6 = gen_color(pix_id); pix_id++;
        pix_valid = 1'b1; pix_color = c6;
        tick();
        pix_color = gen_color(pix_id); pix_id++;
        tick();
        pix_valid = 1'b0;
        check("t6_byte0", byte_data, exp_byte(c6, 0));
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        check("t6_byte1", {byte_valid, byte_data}, {1'b1, exp_byte(c6, 1)});
        check("t6_level_before", level, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", byte_valid, 1'b0);
        check("t6_rst_data", byte_data, 8'h00);
        check("t6_rst_level", level, 0);
        check("t6_rst_ready", pix_ready, 1'b1);
        check("t6_rst_overflow", overflow, 1'b0);
        check("t6_rst_flags", {byte_sof, byte_eof, frame_err}, 3'b000);
        tick();
        reset = 1'b0;
        q.delete();
        m_count = 0;
        m_err   = 1'b0;
        tick();
        check("t6_stays_idle", byte_valid, 1'b0);

        // Full frame after reset: starts at BYTE0, sof on first byte only, eof on last byte only.
        stream("t4", FP, 0, -1, 1, 1'b1, 1'b0);
        check("t4_frame_err", frame_err, 1'b0);
        check("t4_idle", byte_valid, 1'b0);

        // Premature sof at pixel 100 restarts the frame and raises frame_err.
        stream("t5", 120, 0, 100, 1, 1'b1, 1'b0);
        check("t5_frame_err", frame_err, 1'b1);
        check("t5_overflow", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
